booth_mul_param: RTL and testbench

Parametrised sequential radix-2 Booth multiplier with a start/busy/done handshake and per-operation signed/unsigned mode. It is the general-purpose multiply engine for the UART hex calculator datapath and any later block that needs a small-area, multi-cycle multiply. Operands are captured on start, and the product is held stable until the next accepted start. One Booth step is performed per clock.

---
 rtl/booth_pkg.sv | 15 +
 rtl/booth_mul_param_if.sv | 15 +
 rtl/booth_step.sv | 32 +++
 rtl/booth_mul_param.sv | 86 ++++++++
 tb/tb_booth_mul_param.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential radix-2 Booth multiplier.
package booth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Step counter must hold 0..width, sized with headroom for width+1
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/booth_mul_param_if.sv
// Start/busy/done multiply request bus between a requester and the Booth engine.
interface booth_mul_param_if #(
    parameter int unsigned WIDTH = 16
);
    logic                   start;
    logic                   sgn;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (output start, sgn, a, b, input busy, done, product);
    modport slave  (input start, sgn, a, b, output busy, done, product);
endinterface

// File: rtl/booth_step.sv
// One combinational radix-2 Booth step: conditional add/sub of M, then arithmetic shift right.
module booth_step #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [2*WIDTH+2:0] i_acc,
    input  logic [WIDTH:0]     i_m,
    output logic [2*WIDTH+2:0] o_acc
);
    localparam int unsigned EW = WIDTH + 1;
    localparam int unsigned SW = WIDTH + 2;
    localparam int unsigned AW = 2 * WIDTH + 3;

    logic [SW-1:0] w_hi;
    logic [SW-1:0] w_m;
    logic [SW-1:0] w_sum;

    // One extra sign bit keeps the add/sub carry out of the sign position
    assign w_hi = {i_acc[AW-1], i_acc[AW-1 -: EW]};
    assign w_m  = {i_m[EW-1], i_m};

    always_comb begin
        w_sum = w_hi;
        case (i_acc[1:0])
            2'b01:   w_sum = w_hi + w_m;
            2'b10:   w_sum = w_hi - w_m;
            default: w_sum = w_hi;
        endcase
    end

    // Dropping bit 0 of the widened word is the arithmetic shift
    assign o_acc = {w_sum, i_acc[SW-1:1]};
endmodule

// File: rtl/booth_mul_param.sv
// Sequential radix-2 Booth multiplier, one step per clock, signed or unsigned per operation.
module booth_mul_param
    import booth_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    booth_mul_param_if.slave   bus
);
    localparam int unsigned EW = WIDTH + 1;
    localparam int unsigned AW = 2 * WIDTH + 3;
    localparam int unsigned CW = cnt_width(WIDTH);

    state_e               r_state;
    logic [AW-1:0]        r_acc;
    logic [EW-1:0]        r_m;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_product;
    logic                 r_busy;
    logic                 r_done;

    logic [EW-1:0]        w_a_ext;
    logic [EW-1:0]        w_b_ext;
    logic [AW-1:0]        w_acc_init;
    logic [AW-1:0]        w_acc_next;
    logic                 w_last;

    assign w_a_ext    = bus.sgn ? {bus.a[WIDTH-1], bus.a} : {1'b0, bus.a};
    assign w_b_ext    = bus.sgn ? {bus.b[WIDTH-1], bus.b} : {1'b0, bus.b};
    assign w_acc_init = {EW'(0), w_b_ext, 1'b0};
    assign w_last     = (r_cnt == CW'(WIDTH));

    booth_step #(.WIDTH(WIDTH)) u_step (
        .i_acc (r_acc),
        .i_m   (r_m),
        .o_acc (w_acc_next)
    );

    // Control FSM and datapath registers; busy/done track the state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_acc     <= '0;
            r_m       <= '0;
            r_cnt     <= '0;
            r_product <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_acc   <= w_acc_init;
                        r_m     <= w_a_ext;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_product <= w_acc_next[2*WIDTH:1];
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= ST_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.product = r_product;
endmodule

// File: tb/tb_booth_mul_param.sv
// Scoreboard bench for booth_mul_param at WIDTH=16 (directed) and WIDTH=8 (random).
module tb_booth_mul_param;

    typedef struct {
        logic [63:0] prod;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_errors;
    exp_t q16[$];
    exp_t q8[$];

    booth_mul_param_if #(.WIDTH(16)) bus16();
    booth_mul_param_if #(.WIDTH(8))  bus8();

    booth_mul_param #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
    booth_mul_param #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Output monitors: pop expected result on each done pulse, check latency and busy length
    logic prev16, prev8;
    int   bc16, bc8;
    initial begin prev16 = 0; prev8 = 0; bc16 = 0; bc8 = 0; end

    always @(negedge clk) begin : mon16
        exp_t e;
        if (!rst) begin
            if (bus16.done) begin
                check("done16_single", 64'(prev16), 64'd0);
                check("busy16_len", 64'(bc16), 64'd17);
                if (q16.size() == 0) check("spurious_done16", 64'd1, 64'd0);
                else begin
                    e = q16.pop_front();
                    check("prod16", 64'(bus16.product), e.prod);
                    check("lat16", 64'(cyc), 64'(e.cyc));
                end
            end
            prev16 = bus16.done;
            bc16   = bus16.busy ? bc16 + 1 : 0;
        end
    end

    always @(negedge clk) begin : mon8
        exp_t e;
        if (!rst) begin
            if (bus8.done) begin
                check("done8_single", 64'(prev8), 64'd0);
                check("busy8_len", 64'(bc8), 64'd9);
                if (q8.size() == 0) check("spurious_done8", 64'd1, 64'd0);
                else begin
                    e = q8.pop_front();
                    check("prod8", 64'(bus8.product), e.prod);
                    check("lat8", 64'(cyc), 64'(e.cyc));
                end
            end
            prev8 = bus8.done;
            bc8   = bus8.busy ? bc8 + 1 : 0;
        end
    end

    task automatic go16(input logic s, input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp);
        exp_t e;
        @(posedge clk); #1;
        bus16.sgn = s; bus16.a = a; bus16.b = b; bus16.start = 1'b1;
        e.prod = 64'(exp); e.cyc = cyc + 18;
        q16.push_back(e);
        @(posedge clk); #1;
        bus16.start = 1'b0;
    endtask

    task automatic wait16(input int lim);
        int n;
        @(negedge clk); n = 1;
        while (!bus16.done && n < lim) begin @(negedge clk); n++; end
        if (!bus16.done) check("timeout16", 64'd0, 64'd1);
    endtask

    task automatic go8(input logic s, input logic [7:0] a, input logic [7:0] b);
        exp_t   e;
        longint ea, eb;
        ea = s ? longint'($signed(a)) : longint'(a);
        eb = s ? longint'($signed(b)) : longint'(b);
        @(posedge clk); #1;
        bus8.sgn = s; bus8.a = a; bus8.b = b; bus8.start = 1'b1;
        e.prod = 64'((ea * eb) & 64'hFFFF); e.cyc = cyc + 10;
        q8.push_back(e);
        @(posedge clk); #1;
        bus8.start = 1'b0;
    endtask

    task automatic wait8(input int lim);
        int n;
        @(negedge clk); n = 1;
        while (!bus8.done && n < lim) begin @(negedge clk); n++; end
        if (!bus8.done) check("timeout8", 64'd0, 64'd1);
    endtask

    initial begin : stim
        exp_t e;
        int   k;
        n_checks = 0; n_errors = 0;
        rst = 1'b1;
        bus16.start = 1'b1; bus16.sgn = 1'b0; bus16.a = 16'd3; bus16.b = 16'd3;
        bus8.start  = 1'b1; bus8.sgn  = 1'b0; bus8.a  = 8'd3;  bus8.b  = 8'd3;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; bus16.start = 1'b0; bus8.start = 1'b0;
        @(negedge clk);
        check("rst_busy16", 64'(bus16.busy), 64'd0);
        check("rst_done16", 64'(bus16.done), 64'd0);
        check("rst_prod16", 64'(bus16.product), 64'd0);
        check("rst_busy8",  64'(bus8.busy), 64'd0);
        check("rst_prod8",  64'(bus8.product), 64'd0);

        // Directed WIDTH=16 products
        go16(1'b1, 16'hFFFD, 16'h0005, 32'hFFFF_FFF1); wait16(40);
        go16(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001); wait16(40);
        go16(1'b1, 16'h8000, 16'h8000, 32'h4000_0000); wait16(40);
        go16(1'b1, 16'h8000, 16'h7FFF, 32'hC000_8000); wait16(40);

        // Start re-pulsed mid-RUN with other operands must be ignored
        go16(1'b0, 16'd100, 16'd200, 32'd20000);
        repeat (4) @(posedge clk);
        #1;
        bus16.sgn = 1'b1; bus16.a = 16'h1234; bus16.b = 16'h5678; bus16.start = 1'b1;
        @(posedge clk); #1;
        bus16.start = 1'b0;
        wait16(40);
        @(negedge clk);
        check("ignored_start_busy", 64'(bus16.busy), 64'd0);

        // Reset mid-RUN aborts the op and clears the product
        go16(1'b0, 16'd9, 16'd9, 32'd81);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q16.delete();
        @(negedge clk);
        check("midrst_busy", 64'(bus16.busy), 64'd0);
        check("midrst_done", 64'(bus16.done), 64'd0);
        check("midrst_prod", 64'(bus16.product), 64'd0);
        go16(1'b0, 16'd7, 16'd6, 32'd42); wait16(40);

        // Back-to-back: start held through DONE, operands changed during first RUN
        @(posedge clk); #1;
        bus16.sgn = 1'b0; bus16.a = 16'd1000; bus16.b = 16'd3; bus16.start = 1'b1;
        k = cyc;
        e.prod = 64'd3000;   e.cyc = k + 18; q16.push_back(e);
        e.prod = 64'd150000; e.cyc = k + 36; q16.push_back(e);
        @(posedge clk); #1;
        bus16.a = 16'd500; bus16.b = 16'd300;
        wait16(40);
        @(posedge clk); #1;
        bus16.start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("b2b_hold_prod", 64'(bus16.product), 64'd3000);
        check("b2b_busy", 64'(bus16.busy), 64'd1);
        wait16(40);
        repeat (3) @(negedge clk);
        check("b2b_idle_after", 64'(bus16.busy), 64'd0);
        check("q16_drained", 64'(q16.size()), 64'd0);

        // Random WIDTH=8 ops in both modes
        for (int i = 0; i < 1000; i++) begin
            go8(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            wait8(20);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        repeat (3) @(negedge clk);
        check("q8_drained", 64'(q8.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
